// File: rtl/alu_regfile_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_regfile_ctrl
// Purpose  : Sequencing stage wrapped around a combinational four-function ALU.
//            It holds an NREG x DATA_W register file and accepts one
//            instruction per handshake. It drives the ALU operand and op
//            ports from registered values. It captures the ALU result and
//            carry-out, then writes the result back to the destination
//            register. Load-immediate instructions write the register file
//            without going through the ALU.
// Ports    : clk_i, rst_ni        clock (rising edge), synchronous active-low reset
//            in_valid_i/in_ready_o instruction handshake
//            in_ld_i, in_op_i      load-immediate select, ALU op (ADD/SUB/AND/OR)
//            in_rd_i/rs1_i/rs2_i   destination / operand A / operand B register
//            in_imm_i              immediate for loads
//            alu_op_o/a_o/b_o      registered ALU drive
//            alu_o_i, alu_cout_i   ALU result and carry-out
//            done_o, wb_data_o     write-back pulse and value
//            carry_flag_o          last arithmetic carry-out
//            zero_flag_o           last ALU result was zero (optional)
//            dbg_addr_i/dbg_data_o combinational register read port
// Config   : define ALU_ZERO_FLAG_EN to add zero_flag_o
// Revision : 1.0 - initial release
// ============================================================================
module alu_regfile_ctrl #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic                      in_ld_i,
  input  logic [1:0]                in_op_i,
  input  logic [$clog2(NREG)-1:0]   in_rd_i,
  input  logic [$clog2(NREG)-1:0]   in_rs1_i,
  input  logic [$clog2(NREG)-1:0]   in_rs2_i,
  input  logic [DATA_W-1:0]         in_imm_i,
  output logic [1:0]                alu_op_o,
  output logic [DATA_W-1:0]         alu_a_o,
  output logic [DATA_W-1:0]         alu_b_o,
  input  logic [DATA_W-1:0]         alu_o_i,
  input  logic                      alu_cout_i,
  output logic                      done_o,
  output logic [DATA_W-1:0]         wb_data_o,
  output logic                      carry_flag_o,
`ifdef ALU_ZERO_FLAG_EN
  output logic                      zero_flag_o,
`endif
  input  logic [$clog2(NREG)-1:0]   dbg_addr_i,
  output logic [DATA_W-1:0]         dbg_data_o
);

  localparam int AW = $clog2(NREG);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     rd_q;
  logic [1:0]        alu_op_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [DATA_W-1:0] result_q;
  logic              carry_q;
  logic [DATA_W-1:0] regs_q [NREG];
`ifdef ALU_ZERO_FLAG_EN
  logic              zero_q;
`endif

  logic accept;

  // Ready is masked by reset so nothing is accepted while rst_ni is low.
  assign in_ready_o = rst_ni && (state_q == ST_IDLE);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = in_ld_i ? ST_WB : ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      rd_q     <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;

      // Operands are sampled from the register file at accept time, so a
      // source equal to the destination sees the pre-write value.
      if (accept) begin
        rd_q <= in_rd_i;
        if (in_ld_i) begin
          result_q <= in_imm_i;
        end else begin
          alu_op_q <= in_op_i;
          alu_a_q  <= regs_q[in_rs1_i];
          alu_b_q  <= regs_q[in_rs2_i];
        end
      end

      if (state_q == ST_EXEC) begin
        result_q <= alu_o_i;
        // Only ADD/SUB (op[1] = 0) produce a meaningful carry.
        if (!alu_op_q[1]) carry_q <= alu_cout_i;
`ifdef ALU_ZERO_FLAG_EN
        zero_q <= (alu_o_i == '0);
`endif
      end

      if (state_q == ST_WB) regs_q[rd_q] <= result_q;
    end
  end

  assign alu_op_o     = alu_op_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign done_o       = (state_q == ST_WB);
  assign wb_data_o    = (state_q == ST_WB) ? result_q : '0;
  assign carry_flag_o = carry_q;
`ifdef ALU_ZERO_FLAG_EN
  assign zero_flag_o  = zero_q;
`endif
  assign dbg_data_o   = regs_q[dbg_addr_i];

endmodule
`default_nettype wire
